// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package keypad_pkg;
  localparam int COLS  = 4;
  localparam int ROWS  = 4;
  localparam int KEY_W = 4;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD} state_t;

  // Index of the set bit in a one-hot row vector; zero when none is set.
  function automatic logic [1:0] onehot_idx(input logic [ROWS-1:0] v);
    onehot_idx = 2'd0;
    for (int i = 0; i < ROWS; i++)
      if (v[i]) onehot_idx = 2'(i);
  endfunction
endpackage

// File: rtl/scan_tick_sync.sv
// Synchronises the divided scan clock and emits a one-cycle tick on each rising edge.
module scan_tick_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic scan_clock,
  output logic tick
);
  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync <= '0;
      prev <= 1'b0;
      tick <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], scan_clock};
      prev <= sync[SYNC_STAGES-1];
      tick <= sync[SYNC_STAGES-1] & ~prev;
    end
  end
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner with debounce and valid/ready key output.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 200,
  parameter int REPEAT_TICKS   = 5000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             scan_clock,
  input  logic [ROWS-1:0]  row_in,
  output logic [COLS-1:0]  col_out,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  input  logic             key_ready,
  output logic             overrun
);
  localparam int DB_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_TICKS - 1);

  if (SYNC_STAGES < 2 || DEBOUNCE_TICKS < 2 || REPEAT_TICKS < 1) begin : g_bad_param
    $error("keypad_scanner: invalid parameter");
  end

  logic tick;
  scan_tick_sync #(.SYNC_STAGES(SYNC_STAGES)) u_tick (
    .clock(clock), .reset(reset), .scan_clock(scan_clock), .tick(tick)
  );

  logic [SYNC_STAGES-1:0][ROWS-1:0] row_sync;
  always_ff @(posedge clock) begin
    if (!reset) row_sync <= '1;
    else        row_sync <= {row_sync[SYNC_STAGES-2:0], row_in};
  end

  state_t           state, state_n;
  logic [1:0]       col, col_n;
  logic [KEY_W-1:0] cand, cand_n, key_code_n;
  logic [DB_W-1:0]  cnt, cnt_n, cnt_inc;
  logic             key_valid_n, overrun_n, emit;
  logic [ROWS-1:0]  low;
  logic             single;

  assign low     = ~row_sync[SYNC_STAGES-1];
  // Ghost patterns (several rows low) are never treated as a key.
  assign single  = (low != '0) && ((low & (low - 4'd1)) == '0);
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
  assign col_out = ~(4'(1) << col);

`ifdef KEYPAD_REPEAT_EN
  localparam int RP_W = $clog2(REPEAT_TICKS + 1);
  logic [RP_W-1:0] rep, rep_n, rep_inc;
  assign rep_inc = (rep == '1) ? rep : rep + 1'b1;
  always_ff @(posedge clock) begin
    if (!reset) rep <= '0;
    else        rep <= rep_n;
  end
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= SCAN;
      col       <= 2'd0;
      cand      <= '0;
      cnt       <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      col       <= col_n;
      cand      <= cand_n;
      cnt       <= cnt_n;
      key_code  <= key_code_n;
      key_valid <= key_valid_n;
      overrun   <= overrun_n;
    end
  end

  always_comb begin
    state_n = state;
    col_n   = col;
    cand_n  = cand;
    cnt_n   = cnt;
    emit    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_n   = rep;
`endif
    if (tick) begin
      case (state)
        SCAN: begin
          if (single) begin
            cand_n  = {onehot_idx(low), col};
            cnt_n   = '0;
            state_n = DEBOUNCE;
          end else begin
            col_n = col + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (low == (4'(1) << cand[3:2])) begin
            cnt_n = cnt_inc;
            if (cnt_inc >= DB_LAST) begin
              emit    = 1'b1;
              cnt_n   = '0;
              state_n = HOLD;
`ifdef KEYPAD_REPEAT_EN
              rep_n   = '0;
`endif
            end
          end else begin
            state_n = SCAN;
            col_n   = col + 2'd1;
          end
        end
        HOLD: begin
          if (low == '0) begin
            cnt_n = cnt_inc;
            if (cnt_inc >= DB_LAST) begin
              cnt_n   = '0;
              state_n = SCAN;
              col_n   = col + 2'd1;
            end
          end else begin
            cnt_n = '0;
          end
`ifdef KEYPAD_REPEAT_EN
          if (low == '0) begin
            rep_n = '0;
          end else if (rep_inc >= RP_W'(REPEAT_TICKS)) begin
            emit  = 1'b1;
            rep_n = '0;
          end else begin
            rep_n = rep_inc;
          end
`endif
        end
        default: state_n = SCAN;
      endcase
    end
  end

  // A code is taken if the slot is free or is being consumed on this very edge.
  always_comb begin
    key_valid_n = key_valid;
    key_code_n  = key_code;
    overrun_n   = overrun;
    if (key_valid && key_ready) begin
      key_valid_n = 1'b0;
      overrun_n   = 1'b0;
    end
    if (emit) begin
      if (!key_valid || key_ready) begin
        key_code_n  = cand;
        key_valid_n = 1'b1;
      end else begin
        overrun_n = 1'b1;
      end
    end
  end
endmodule
